// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard request / redirect / status bundle between the pipeline and pipe_ctrl.
// master = pipeline side (drives requests), slave = pipe_ctrl side (drives controls).
`ifndef StallBus
`define StallBus 6:0
`endif

interface pipe_ctrl_if;
    logic              stallreq_if;
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              stallreq_mem;
    logic              br_e;
    logic [31:0]       br_target;
    logic [`StallBus]  stall;
    logic              flush;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              wdt_err;
    logic [31:0]       perf_ld_cnt;
    logic [31:0]       perf_ex_cnt;
    logic [31:0]       perf_mem_cnt;
    logic [31:0]       perf_br_cnt;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, br_e, br_target,
        input  stall, flush, redirect_valid, redirect_pc, wdt_err,
        input  perf_ld_cnt, perf_ex_cnt, perf_mem_cnt, perf_br_cnt
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, br_e, br_target,
        output stall, flush, redirect_valid, redirect_pc, wdt_err,
        output perf_ld_cnt, perf_ex_cnt, perf_mem_cnt, perf_br_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: priority stall generation, deferred branch redirect and sticky stall watchdog.
// Define PIPE_CTRL_PERF_EN to build the four performance counters (outputs tie to 0 otherwise).
`ifndef StallBus
`define StallBus 6:0
`endif

module pipe_ctrl #(
    parameter int unsigned WDT_LIMIT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = (WDT_LIMIT < 1) ? 1 : $clog2(WDT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WDT_LIMIT);

    logic [`StallBus]  stall;
    logic              stall_pc;

    logic              pend_v_q,    pend_v_d;
    logic [31:0]       pend_pc_q,   pend_pc_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              wdt_err_q,   wdt_err_d;

    // Highest stage wins; each request holds its own stage and everything upstream.
    always_comb begin
        stall = '0;
        if (bus.stallreq_mem) begin
            stall = 7'h7F;
        end else if (bus.stallreq_ex) begin
            stall = 7'h1F;
        end else if (bus.stallreq_id) begin
            stall = 7'h0F;
        end else if (bus.stallreq_if) begin
            stall = 7'h03;
        end
    end

    assign stall_pc = stall[0];

    always_comb begin
        pend_v_d  = pend_v_q;
        pend_pc_d = pend_pc_q;
        if (bus.br_e) begin
            if (stall_pc) begin
                pend_v_d  = 1'b1;
                pend_pc_d = bus.br_target;
            end else begin
                pend_v_d  = 1'b0;
            end
        end else if (pend_v_q && !stall_pc) begin
            pend_v_d = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = '0;
        if (stall_pc) begin
            stall_cnt_d = (stall_cnt_q == CNT_LIMIT) ? stall_cnt_q : stall_cnt_q + 1'b1;
        end
        wdt_err_d = wdt_err_q | (stall_cnt_d == CNT_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_q    <= 1'b0;
            pend_pc_q   <= '0;
            stall_cnt_q <= '0;
            wdt_err_q   <= 1'b0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_pc_q   <= pend_pc_d;
            stall_cnt_q <= stall_cnt_d;
            wdt_err_q   <= wdt_err_d;
        end
    end

    assign bus.stall          = stall;
    assign bus.redirect_valid = bus.br_e | pend_v_q;
    assign bus.flush          = bus.br_e | pend_v_q;
    assign bus.redirect_pc    = bus.br_e ? bus.br_target : pend_pc_q;
    assign bus.wdt_err        = wdt_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_ld_q,  perf_ld_d;
    logic [31:0] perf_ex_q,  perf_ex_d;
    logic [31:0] perf_mem_q, perf_mem_d;
    logic [31:0] perf_br_q,  perf_br_d;

    always_comb begin
        perf_ld_d  = perf_ld_q  + {31'd0, (stall == 7'h0F)};
        perf_ex_d  = perf_ex_q  + {31'd0, (stall == 7'h1F)};
        perf_mem_d = perf_mem_q + {31'd0, (stall == 7'h7F)};
        perf_br_d  = perf_br_q  + {31'd0, bus.br_e};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ld_q  <= '0;
            perf_ex_q  <= '0;
            perf_mem_q <= '0;
            perf_br_q  <= '0;
        end else begin
            perf_ld_q  <= perf_ld_d;
            perf_ex_q  <= perf_ex_d;
            perf_mem_q <= perf_mem_d;
            perf_br_q  <= perf_br_d;
        end
    end

    assign bus.perf_ld_cnt  = perf_ld_q;
    assign bus.perf_ex_cnt  = perf_ex_q;
    assign bus.perf_mem_cnt = perf_mem_q;
    assign bus.perf_br_cnt  = perf_br_q;
`else
    assign bus.perf_ld_cnt  = '0;
    assign bus.perf_ex_cnt  = '0;
    assign bus.perf_mem_cnt = '0;
    assign bus.perf_br_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench; a driver pushes model predictions, a negedge monitor pops and compares.
module tb_pipe_ctrl;
    localparam int unsigned WDT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.WDT_LIMIT(WDT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          known;
        logic [6:0]  stall;
        logic        rv;
        logic        flush;
        bit          pc_chk;
        logic [31:0] pc;
        logic        wdt;
        logic [31:0] ld, ex, mem, br;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: pending targets as a queue, consecutive-stall run length.
    logic [31:0] pend_q[$];
    bit          known = 0;
    int          run   = 0;
    bit          m_wdt = 0;
    logic [31:0] m_ld = '0, m_ex = '0, m_mem = '0, m_br = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit rif, input bit rid, input bit rex,
                       input bit rmem, input bit be, input logic [31:0] tgt);
        exp_t x;
        int   n;
        logic [6:0] s;
        @(posedge clk);
        #1;
        rst              = r;
        bus.stallreq_if  = rif;
        bus.stallreq_id  = rid;
        bus.stallreq_ex  = rex;
        bus.stallreq_mem = rmem;
        bus.br_e         = be;
        bus.br_target    = tgt;

        n = rmem ? 7 : rex ? 5 : rid ? 4 : rif ? 2 : 0;
        s = 7'((1 << n) - 1);

        x.known  = known;
        x.stall  = s;
        x.rv     = be || (pend_q.size() != 0);
        x.flush  = x.rv;
        x.pc_chk = x.rv;
        x.pc     = be ? tgt : (pend_q.size() != 0 ? pend_q[0] : 32'h0);
        x.wdt    = m_wdt;
`ifdef PIPE_CTRL_PERF_EN
        x.ld = m_ld; x.ex = m_ex; x.mem = m_mem; x.br = m_br;
`else
        x.ld = '0; x.ex = '0; x.mem = '0; x.br = '0;
`endif
        exp_q.push_back(x);

        if (r) begin
            pend_q.delete();
            known = 1;
            run   = 0;
            m_wdt = 0;
            m_ld = '0; m_ex = '0; m_mem = '0; m_br = '0;
        end else begin
            if (be) begin
                pend_q.delete();
                if (s[0]) pend_q.push_back(tgt);
            end else if (!s[0]) begin
                pend_q.delete();
            end
            run = s[0] ? run + 1 : 0;
            if (run >= int'(WDT)) m_wdt = 1;
            if (n == 4) m_ld++;
            if (n == 5) m_ex++;
            if (n == 7) m_mem++;
            if (be) m_br++;
        end
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) cyc(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("stall", {25'd0, bus.stall}, {25'd0, e.stall});
                if (e.known) begin
                    chk("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, e.rv});
                    chk("flush", {31'd0, bus.flush}, {31'd0, e.flush});
                    if (e.pc_chk) chk("redirect_pc", bus.redirect_pc, e.pc);
                    chk("wdt_err", {31'd0, bus.wdt_err}, {31'd0, e.wdt});
                    chk("perf_ld", bus.perf_ld_cnt, e.ld);
                    chk("perf_ex", bus.perf_ex_cnt, e.ex);
                    chk("perf_mem", bus.perf_mem_cnt, e.mem);
                    chk("perf_br", bus.perf_br_cnt, e.br);
                end
            end
        end
    end

    initial begin : driver
        bus.stallreq_if  = 0;
        bus.stallreq_id  = 0;
        bus.stallreq_ex  = 0;
        bus.stallreq_mem = 0;
        bus.br_e         = 0;
        bus.br_target    = '0;

        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        idle(1);

        // id+ex together, then ex drops
        cyc(0, 0, 1, 1, 0, 0, 32'h0);
        cyc(0, 0, 1, 0, 0, 0, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 32'h0);
        idle(1);

        // unstalled redirect
        cyc(0, 0, 0, 0, 0, 1, 32'h8000_0100);
        idle(2);

        // redirect deferred across a 3-cycle mem stall
        cyc(0, 0, 0, 0, 1, 1, 32'h8000_0200);
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        idle(2);

        // pending target overwritten while still stalled
        cyc(0, 0, 0, 0, 1, 1, 32'h8000_0200);
        cyc(0, 0, 0, 0, 1, 1, 32'h8000_0300);
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        idle(2);

        // new unstalled branch beats a pending one
        cyc(0, 0, 0, 1, 0, 1, 32'h1234_5678);
        cyc(0, 0, 0, 0, 0, 1, 32'hCAFE_0000);
        idle(2);

        // reset while a redirect is pending
        cyc(0, 0, 0, 0, 1, 1, 32'hDEAD_0000);
        cyc(1, 0, 0, 0, 1, 0, 32'h0);
        idle(2);

        // watchdog: 7 stalls do not trip, 8 do and it stays sticky
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 0, 0, 32'h0);
        idle(2);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0, 0, 32'h0);
        idle(3);
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        idle(2);

        // perf: 5 load-use cycles and 2 branches
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 32'h0000_1000);
        cyc(0, 0, 0, 0, 0, 1, 32'h0000_2000);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 99) < 20,
                $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 8,
                $urandom_range(0, 99) < 20,
                $urandom);
        end
        idle(1);

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter WDT_LIMIT, default 1024, meaning the number of consecutive PC-stall cycles that raises wdt_err.
REQ-002 SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  the single clock for all state; rising edge.
- rst  in  1  synchronous, active-high reset.
- stallreq_if  in  1  IF1 fetch-miss hold request.
- stallreq_id  in  1  ID load-use or CSR-use hazard request.
- stallreq_ex  in  1  EX multi-cycle mul/div busy request.
- stallreq_mem  in  1  MEM2 data-access miss request.
- br_e  in  1  EX branch or jump mispredict, taken redirect.
- br_target  in  32  redirect PC qualified by br_e.
- stall  out  7 (`StallBus)  per-stage hold: [0] PC, [1] IF1, [2] IF2, [3] ID, [4] EX, [5] MEM1, [6] MEM2.
- flush  out  1  clears the front-end registers (IF1, IF2, ID).
- redirect_valid  out  1  PC-load strobe.
- redirect_pc  out  32  PC-load value.
- wdt_err  out  1  sticky stall-watchdog error.
- perf_ld_cnt, perf_ex_cnt, perf_mem_cnt, perf_br_cnt  out  32 each  performance counters.

Function
REQ-003 stall SHALL be combinational, with highest-stage request winning: stallreq_mem gives 7'h7F; else stallreq_ex gives 7'h1F; else stallreq_id gives 7'h0F; else stallreq_if gives 7'h03; else 7'h00.
REQ-004 A downstream stage receives a bubble when stall[k]=1 and stall[k+1]=0; pipe_ctrl SHALL NOT generate any separate bubble signal.
REQ-005 br_e=1 with stall[0]=0 SHALL assert redirect_valid=1 and redirect_pc=br_target in the same cycle, with no state stored.
REQ-006 br_e=1 with stall[0]=1 SHALL latch br_target into pend_pc and set pend_v on the next edge.
REQ-007 While pend_v=1, redirect_valid SHALL be 1 and redirect_pc SHALL be pend_pc, unless br_e=1 in that cycle; in that case br_target drives redirect_pc and, if stall[0]=1, overwrites pend_pc.
REQ-008 pend_v SHALL clear on the edge ending the first cycle with stall[0]=0, because that cycle consumes the redirect.
REQ-009 If br_e=1 and stall[0]=0 while pend_v=1, pend_v SHALL clear and br_target wins.
REQ-010 flush SHALL be br_e | pend_v; flush is asserted for every cycle a redirect is outstanding or presented.
REQ-011 stall_cnt, a counter wide enough for WDT_LIMIT, SHALL increment on each cycle with stall[0]=1, saturate at WDT_LIMIT, and clear on any cycle with stall[0]=0.
REQ-012 wdt_err SHALL set on the edge at which stall_cnt reaches WDT_LIMIT and remain 1 until rst; stalls continue to be honoured after it sets.
REQ-013 Simultaneous requests SHALL be resolved only by REQ-003; lower-priority requests are not queued.

Reset
REQ-014 On rst=1 at an edge: pend_v=0, pend_pc=0, stall_cnt=0, wdt_err=0, all perf counters 0.
REQ-015 rst asserted mid-redirect SHALL drop the pending redirect.
REQ-016 During rst, the combinational outputs stall, flush, redirect_valid and redirect_pc SHALL still follow their inputs and the reset state.

Configuration
REQ-017 With macro PIPE_CTRL_PERF_EN defined, the four perf counters SHALL each increment by 1 per cycle (wrapping at 2^32), one condition per counter:
- perf_ld_cnt: stall==7'h0F.
- perf_ex_cnt: stall==7'h1F.
- perf_mem_cnt: stall==7'h7F.
- perf_br_cnt: br_e=1.
REQ-018 Without PIPE_CTRL_PERF_EN, the perf outputs SHALL be constant 0 and no counter flops SHALL be instantiated.

Verification
REQ-019 stallreq_id=1 and stallreq_ex=1 in the same cycle -> stall=7'h1F; drop stallreq_ex -> stall=7'h0F.
REQ-020 br_e=1, br_target=32'h8000_0100, no stalls -> redirect_valid=1, redirect_pc=32'h8000_0100, flush=1 in that cycle only; pend_v stays 0.
REQ-021 stallreq_mem=1 for 3 cycles, br_e=1 with target 32'h8000_0200 in the first of them -> redirect_valid and flush stay 1 through the cycle stall[0] falls, then 0 on the next cycle.
REQ-022 Pending target 32'h8000_0200, then br_e with 32'h8000_0300 while still stalled -> redirect_pc=32'h8000_0300 when consumed.
REQ-023 WDT_LIMIT=8, stallreq_if held 8 cycles -> wdt_err=1 after the 8th edge and stays 1 after the stall drops; rst pulse -> 0.
REQ-024 PIPE_CTRL_PERF_EN defined: 5 load-use cycles and 2 br_e cycles -> perf_ld_cnt=5, perf_br_cnt=2. Undefined: all perf outputs 0.
